bus_memory_responder: RTL and testbench

- Word-organised memory responder on the far end of the core's bus master port; serves instruction/data load and store requests from the execute unit.
- Single outstanding transaction: accepts a request, inserts a programmable number of wait states, then holds a response until the master takes it.
- Supports byte-lane writes, range and alignment checking with an error response, and backpressure on both request and response channels.

---
 rtl/bus_memory_responder.sv | 159 +++++++++++++++
 tb/tb_bus_memory_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_responder.sv
// Single-outstanding word memory responder for the core's bus master port.
// Requests are accepted in IDLE, delayed WAIT_STATES cycles, then the response is held until taken.
module bus_memory_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_commit;

  logic [31:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_error;

  logic [31:0] r_mem [0:DEPTH_WORDS-1];

  logic [31:0]      w_addr;
  logic             w_write;
  logic [31:0]      w_wdata;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_offset;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic             w_accept;
  logic             w_mem_we;

  // With zero wait states the access commits on the accept edge, so it must
  // use the live request rather than the latched copy.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_addr  = req_addr;
      w_write = req_write;
      w_wdata = req_wdata;
      w_wstrb = req_wstrb;
    end else begin
      w_addr  = r_addr;
      w_write = r_write;
      w_wdata = r_wdata;
      w_wstrb = r_wstrb;
    end
  end

  // BASE_ADDR is aligned to the region size, so any set bit above the index
  // (including wrap from addresses below the base) means out of range.
  assign w_offset = w_addr - BASE_ADDR;
  assign w_err    = (w_offset[31:IDX_W+2] != '0) || (w_offset[1:0] != 2'b00);
  assign w_idx    = w_offset[IDX_W+1:2];
  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_mem_we = reset && w_commit && w_write && !w_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            w_commit     = 1'b1;
            w_state_next = S_RESPOND;
          end else begin
            w_cnt_next   = WAIT_INIT;
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_commit     = 1'b1;
          w_state_next = S_RESPOND;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESPOND: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr  <= 32'd0;
      r_write <= 1'b0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_write <= req_write;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
      end
      if (w_commit) begin
        r_error <= w_err;
        r_rdata <= (!w_err && !w_write) ? r_mem[w_idx] : 32'd0;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wstrb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_error = r_error;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: instance A (base 0, 1 wait state)
// and instance B (base 0x1000, no wait states).
module tb_bus_memory_responder;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_error;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [3:0]  a_req_wstrb;
  logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_error;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  bus_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) u_dut_a (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .req_write(a_req_write), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_error(a_resp_error)
  );

  bus_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u_dut_b (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .req_write(b_req_write), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_error(b_resp_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    if (sel == 0) begin
      a_req_valid = v; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata; a_req_wstrb = strb;
    end else begin
      b_req_valid = v; b_req_write = wr; b_req_addr = addr; b_req_wdata = wdata; b_req_wstrb = strb;
    end
  endtask

  task automatic set_rr(input int sel, input logic v);
    if (sel == 0) a_resp_ready = v;
    else          b_resp_ready = v;
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? a_req_ready : b_req_ready;
  endfunction

  function automatic logic vld(input int sel);
    return (sel == 0) ? a_resp_valid : b_resp_valid;
  endfunction

  // One complete transaction; latency counts cycles from the accept edge to
  // the first cycle with resp_valid high.
  task automatic xact(input int sel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err, output int lat);
    int t;
    @(negedge clock);
    drive(sel, 1'b1, wr, addr, wdata, strb);
    t = 0;
    while (!rdy(sel) && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) chk("req_ready_timeout", 32'd1, 32'd0);
    @(posedge clock);
    @(negedge clock);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    lat = 1;
    while (!vld(sel) && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 50) chk("resp_valid_timeout", 32'd1, 32'd0);
    rdata = (sel == 0) ? a_resp_rdata : b_resp_rdata;
    err   = (sel == 0) ? a_resp_error : b_resp_error;
    set_rr(sel, 1'b1);
    @(negedge clock);
    set_rr(sel, 1'b0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          t;

  initial begin
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    a_resp_ready = 1'b0;
    b_resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    chk("rst_a_req_ready", a_req_ready, 1);
    chk("rst_a_resp_valid", a_resp_valid, 0);
    chk("rst_a_rdata", a_resp_rdata, 0);
    chk("rst_a_error", a_resp_error, 0);
    chk("rst_b_req_ready", b_req_ready, 1);
    chk("rst_b_resp_valid", b_resp_valid, 0);

    // Store then load with one wait state
    xact(0, 1, 32'h40, 32'h1234_5678, 4'hF, rd, er, lat);
    chk("st40_lat", lat, 2);
    chk("st40_err", er, 0);
    chk("st40_rdata", rd, 0);
    xact(0, 0, 32'h40, 32'd0, 4'h0, rd, er, lat);
    chk("ld40_lat", lat, 2);
    chk("ld40_rdata", rd, 32'h1234_5678);
    chk("ld40_err", er, 0);

    // Byte lanes
    xact(0, 1, 32'h40, 32'h0000_AB00, 4'b0010, rd, er, lat);
    xact(0, 0, 32'h40, 32'd0, 4'h0, rd, er, lat);
    chk("lane1_rdata", rd, 32'h1234_AB78);
    xact(0, 1, 32'h40, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    chk("strb0_err", er, 0);
    xact(0, 0, 32'h40, 32'd0, 4'h0, rd, er, lat);
    chk("strb0_rdata", rd, 32'h1234_AB78);
    xact(0, 1, 32'h40, 32'hCD00_00EF, 4'b1001, rd, er, lat);
    xact(0, 0, 32'h40, 32'd0, 4'h0, rd, er, lat);
    chk("lane03_rdata", rd, 32'hCD34_ABEF);

    // Range and alignment errors
    xact(0, 1, 32'h0, 32'h0BAD_F00D, 4'hF, rd, er, lat);
    xact(0, 0, 32'h1000, 32'd0, 4'h0, rd, er, lat);
    chk("ld1000_err", er, 1);
    chk("ld1000_rdata", rd, 0);
    xact(0, 0, 32'h42, 32'd0, 4'h0, rd, er, lat);
    chk("ld42_err", er, 1);
    chk("ld42_rdata", rd, 0);
    xact(0, 1, 32'h1000, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("st1000_err", er, 1);
    xact(0, 1, 32'h42, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("st42_err", er, 1);
    xact(0, 0, 32'h0, 32'd0, 4'h0, rd, er, lat);
    chk("word0_unchanged", rd, 32'h0BAD_F00D);
    xact(0, 0, 32'h40, 32'd0, 4'h0, rd, er, lat);
    chk("word40_unchanged", rd, 32'hCD34_ABEF);

    // Response backpressure with a second request held
    xact(0, 1, 32'h44, 32'hCAFE_BABE, 4'hF, rd, er, lat);
    @(negedge clock);
    drive(0, 1, 0, 32'h40, 32'd0, 4'h0);
    @(posedge clock);
    @(negedge clock);
    drive(0, 1, 0, 32'h44, 32'd0, 4'h0);
    t = 0;
    while (!a_resp_valid && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) chk("bp_resp_timeout", 32'd1, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", a_resp_valid, 1);
      chk("bp_rdata", a_resp_rdata, 32'hCD34_ABEF);
      chk("bp_req_ready", a_req_ready, 0);
      @(negedge clock);
    end
    a_resp_ready = 1'b1;
    @(negedge clock);
    a_resp_ready = 1'b0;
    chk("bp_idle_resp_valid", a_resp_valid, 0);
    chk("bp_idle_req_ready", a_req_ready, 1);
    @(posedge clock);
    @(negedge clock);
    chk("bp_second_accepted", a_req_ready, 0);
    drive(0, 0, 0, 32'd0, 32'd0, 4'd0);
    t = 0;
    while (!a_resp_valid && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) chk("bp2_resp_timeout", 32'd1, 32'd0);
    chk("bp_second_rdata", a_resp_rdata, 32'hCAFE_BABE);
    a_resp_ready = 1'b1;
    @(negedge clock);
    a_resp_ready = 1'b0;

    // Reset in WAIT aborts the store
    xact(0, 1, 32'h10, 32'h1111_1111, 4'hF, rd, er, lat);
    @(negedge clock);
    drive(0, 1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    @(posedge clock);
    @(negedge clock);
    chk("wait_req_ready", a_req_ready, 0);
    reset = 1'b0;
    drive(0, 0, 0, 32'd0, 32'd0, 4'd0);
    #1;
    chk("rst_wait_req_ready", a_req_ready, 1);
    chk("rst_wait_resp_valid", a_resp_valid, 0);
    @(negedge clock);
    reset = 1'b1;
    xact(0, 0, 32'h10, 32'd0, 4'h0, rd, er, lat);
    chk("aborted_store_rdata", rd, 32'h1111_1111);

    // Reset in RESPOND keeps the committed store
    @(negedge clock);
    drive(0, 1, 1, 32'h14, 32'h2222_2222, 4'hF);
    @(posedge clock);
    @(negedge clock);
    drive(0, 0, 0, 32'd0, 32'd0, 4'd0);
    @(negedge clock);
    chk("respond_valid", a_resp_valid, 1);
    reset = 1'b0;
    #1;
    chk("rst_respond_valid", a_resp_valid, 0);
    chk("rst_respond_rdata", a_resp_rdata, 0);
    @(negedge clock);
    reset = 1'b1;
    xact(0, 0, 32'h14, 32'd0, 4'h0, rd, er, lat);
    chk("committed_store_rdata", rd, 32'h2222_2222);

    // Instance B: zero wait states, base 0x1000
    xact(1, 1, 32'h1000, 32'hA5A5_A5A5, 4'hF, rd, er, lat);
    chk("b_st_lat", lat, 1);
    xact(1, 1, 32'h1004, 32'h5A5A_5A5A, 4'hF, rd, er, lat);
    xact(1, 0, 32'h1000, 32'd0, 4'h0, rd, er, lat);
    chk("b_ld_lat", lat, 1);
    chk("b_ld_rdata", rd, 32'hA5A5_A5A5);
    xact(1, 0, 32'h0FFC, 32'd0, 4'h0, rd, er, lat);
    chk("b_below_base_err", er, 1);
    chk("b_below_base_rdata", rd, 0);

    @(negedge clock);
    b_resp_ready = 1'b1;
    drive(1, 1, 0, 32'h1000, 32'd0, 4'h0);
    chk("b2b_acc0_ready", b_req_ready, 1);
    @(negedge clock);
    chk("b2b_r0_valid", b_resp_valid, 1);
    chk("b2b_r0_rdata", b_resp_rdata, 32'hA5A5_A5A5);
    chk("b2b_r0_req_ready", b_req_ready, 0);
    drive(1, 1, 0, 32'h1004, 32'd0, 4'h0);
    @(negedge clock);
    chk("b2b_idle_ready", b_req_ready, 1);
    chk("b2b_idle_valid", b_resp_valid, 0);
    @(negedge clock);
    chk("b2b_r1_valid", b_resp_valid, 1);
    chk("b2b_r1_rdata", b_resp_rdata, 32'h5A5A_5A5A);
    drive(1, 0, 0, 32'd0, 32'd0, 4'd0);
    @(negedge clock);
    b_resp_ready = 1'b0;
    chk("b2b_done_valid", b_resp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
